tl_ul_sram_responder: RTL
=========================

// Module: tl_ul_sram_responder
// PURPOSE
// - TileLink-UL slave endpoint terminating the A/D channel pair that the bus pass-through stages forward.
// - Accepts Get/PutFullData/PutPartialData on A, services them from an internal word-array SRAM, and returns
//   AccessAck/AccessAckData on D. Illegal requests are answered with a denied response, never dropped.
// - Sits at the leaf of the peripheral crossbar as a scratchpad / test target.
// PARAMETERS
// - DEPTH_WORDS  256          number of 32-bit words; power of two, >= 4
// - BASE_ADDR    32'h8000_0000 byte base address; aligned to DEPTH_WORDS*4
// - SOURCE_W     3            width of a_source/d_source
// - SINK_ID      1'b0         constant driven on d_sink
// PORTS
// - clock      in   1         single clock, all state on rising edge
// - reset      in   1         synchronous, active-high
// - a_valid    in   1         A beat valid
// - a_ready    out  1         A beat accepted when a_valid & a_ready
// - a_opcode   in   3         0 PutFull, 1 PutPartial, 4 Get; others unsupported
// - a_param    in   3         must be 0
// - a_size     in   3         log2 bytes
// - a_source   in   SOURCE_W  requester tag, echoed on D
// - a_address  in   32        byte address
// - a_mask     in   4         byte lanes
// - a_data     in   32        write data
// - a_corrupt  in   1         write data poisoned
// - d_valid    out  1         D beat valid
// - d_ready    in   1         D beat taken when d_valid & d_ready
// - d_opcode   out  3         0 AccessAck, 1 AccessAckData
// - d_param    out  2         always 0
// - d_size     out  3         echo of a_size
// - d_source   out  SOURCE_W  echo of a_source
// - d_sink     out  1         SINK_ID
// - d_denied   out  1         request rejected
// - d_data     out  32        read data (0 when not AccessAckData or denied)
// - d_corrupt  out  1         d_data not valid
// BEHAVIOUR
// - Reset: d_valid=0, d_opcode/d_size/d_source/d_data=0, d_denied=0, d_corrupt=0; SRAM contents not reset.
// - a_ready = ~d_valid | d_ready (single-entry response register; full throughput when D not stalled).
// - Latency: A fire at edge N -> response registered at N, d_valid high in cycle N+1. D fields stable while
//   d_valid & ~d_ready. Reset mid-stall discards the pending response.
// - Legality (deny if any fails): opcode in {0,1,4}; a_param==0; a_size<=2; address aligned to 2^a_size;
//   BASE_ADDR <= address < BASE_ADDR+DEPTH_WORDS*4; for PutFull, a_mask equals the full lane mask for
//   size/offset; for PutPartial, a_mask nonzero and within that lane mask.
// - Legal Put: bytes with mask=1 written at A fire; d_opcode=0, denied=0, corrupt=0.
//   Put with a_corrupt=1: write suppressed, d_opcode=0, d_denied=1.
// - Legal Get: word index = (address-BASE_ADDR)>>2; d_data = full word read at A fire; d_opcode=1.
// - Denied Get: d_opcode=1, d_denied=1, d_corrupt=1, d_data=0. Denied other: d_opcode=0, d_denied=1, no write.
// - Unsupported opcodes (2,3,5,6,7) answered with d_opcode=0 (AccessAck) and d_denied=1.
// - Write at N followed by Get of same word at N+1 returns new data (array written before next read).
// - d_param=0, d_sink=SINK_ID always.
// STRUCTURE
// - Package tl_ul_pkg: A/D opcode constants, a_chan_t/d_chan_t structs, lane-mask function full_mask(size,off).
// - Sub-module tl_ul_req_check: combinational legality check -> {legal, is_get, is_put, word_idx}.
// - Top: SRAM register array, response register, a_ready logic.
// TESTING
// - PutFull 0x8000_0010 data 0xDEADBEEF mask 0xF, then Get same -> AccessAck, then AccessAckData 0xDEADBEEF.
// - PutPartial 0x8000_0012 size1 mask 0xC data 0x1234_0000 over 0xDEADBEEF -> Get returns 0x1234BEEF.
// - Get 0x8000_0001 size 2 (misaligned) -> d_opcode=1, denied=1, corrupt=1, data=0; SRAM unchanged.
// - Opcode 2 (Arithmetic) and address BASE+DEPTH_WORDS*4 -> AccessAck denied=1, no write.
// - Hold d_ready=0 for 5 cycles with a_valid high -> a_ready=0, D fields stable; release -> one beat/cycle.
// - Back-to-back 8 Gets with d_ready=1, sources 0..7 -> 8 responses in order, sources echoed, 1-cycle latency.

Source files
------------

// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL definitions: channel opcodes, A/D beat structs, byte-lane mask helper.
// Pure declarations; no logic, no latency.
// No flow control here; users own their handshakes.
package tl_ul_pkg;

    localparam logic [2:0] A_PUT_FULL        = 3'd0;
    localparam logic [2:0] A_PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] A_GET             = 3'd4;
    localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [2:0]  size;
        logic [31:0] address;
        logic [3:0]  mask;
        logic [31:0] data;
        logic        corrupt;
    } a_chan_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  param;
        logic [2:0]  size;
        logic        denied;
        logic [31:0] data;
        logic        corrupt;
    } d_chan_t;

    // Lanes a beat of 2^size bytes at byte offset off occupies; 0 for sizes wider than the bus.
    function automatic logic [3:0] full_mask(input logic [2:0] size, input logic [1:0] off);
        case (size)
            3'd0:    return 4'b0001 << off;
            3'd1:    return off[1] ? 4'b1100 : 4'b0011;
            3'd2:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/tl_ul_req_check.sv
// Legality check of one A-channel beat; decodes Get/Put and the SRAM word index.
// Combinational, zero latency.
// No backpressure; evaluated every cycle regardless of a_valid.
module tl_ul_req_check
    import tl_ul_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    localparam int         IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic [2:0]       opcode,
    input  logic [2:0]       param,
    input  logic [2:0]       size,
    input  logic [31:0]      address,
    input  logic [3:0]       mask,
    output logic             legal,
    output logic             is_get,
    output logic             is_put,
    output logic [IDX_W-1:0] word_idx
);

    localparam int AW = IDX_W + 2;

    logic [3:0] lane_mask;
    logic       aligned;
    logic       in_range;
    logic       mask_ok;

    always_comb begin
        is_get    = (opcode == A_GET);
        is_put    = (opcode == A_PUT_FULL) || (opcode == A_PUT_PARTIAL);
        lane_mask = full_mask(size, address[1:0]);

        // Sizes above one word fall into default and are rejected here.
        case (size)
            3'd0:    aligned = 1'b1;
            3'd1:    aligned = ~address[0];
            3'd2:    aligned = (address[1:0] == 2'b00);
            default: aligned = 1'b0;
        endcase

        // BASE_ADDR is aligned to the window size, so a high-bit compare is the range check.
        in_range = (address[31:AW] == BASE_ADDR[31:AW]);

        case (opcode)
            A_PUT_FULL:    mask_ok = (mask == lane_mask);
            A_PUT_PARTIAL: mask_ok = (mask != 4'b0000) && ((mask & ~lane_mask) == 4'b0000);
            default:       mask_ok = 1'b1;
        endcase

        legal    = (is_get || is_put) && (param == 3'd0) && aligned && in_range && mask_ok;
        word_idx = address[AW-1:2];
    end

endmodule

// File: rtl/tl_ul_sram_responder.sv
// TileLink-UL slave: Get/PutFull/PutPartial serviced from a word SRAM, illegal beats answered denied.
// Latency: A fire at edge N, D beat valid from cycle N+1.
// Single response register: a_ready = ~d_valid | d_ready, D fields held while stalled.
module tl_ul_sram_responder
    import tl_ul_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          SOURCE_W    = 3,
    parameter logic        SINK_ID     = 1'b0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [2:0]          a_opcode,
    input  logic [2:0]          a_param,
    input  logic [2:0]          a_size,
    input  logic [SOURCE_W-1:0] a_source,
    input  logic [31:0]         a_address,
    input  logic [3:0]          a_mask,
    input  logic [31:0]         a_data,
    input  logic                a_corrupt,
    output logic                d_valid,
    input  logic                d_ready,
    output logic [2:0]          d_opcode,
    output logic [1:0]          d_param,
    output logic [2:0]          d_size,
    output logic [SOURCE_W-1:0] d_source,
    output logic                d_sink,
    output logic                d_denied,
    output logic [31:0]         d_data,
    output logic                d_corrupt
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    a_chan_t             a_beat;
    d_chan_t             d_nxt;
    d_chan_t             d_q;
    logic [SOURCE_W-1:0] src_q;
    logic                d_vld_q;
    logic                legal;
    logic                is_get;
    logic                is_put;
    logic [IDX_W-1:0]    word_idx;
    logic                a_fire;
    logic                wr_en;
    logic [31:0]         mem [DEPTH_WORDS];

    assign a_beat = '{opcode: a_opcode, param: a_param, size: a_size, address: a_address,
                      mask: a_mask, data: a_data, corrupt: a_corrupt};

    tl_ul_req_check #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .BASE_ADDR   (BASE_ADDR)
    ) u_req_check (
        .opcode   (a_beat.opcode),
        .param    (a_beat.param),
        .size     (a_beat.size),
        .address  (a_beat.address),
        .mask     (a_beat.mask),
        .legal    (legal),
        .is_get   (is_get),
        .is_put   (is_put),
        .word_idx (word_idx)
    );

    assign a_ready = ~d_vld_q | d_ready;
    assign a_fire  = a_valid & a_ready;
    assign wr_en   = a_fire & ~reset & legal & is_put & ~a_beat.corrupt;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (a_beat.mask[i]) mem[word_idx][8*i +: 8] <= a_beat.data[8*i +: 8];
            end
        end
    end

    // Unsupported opcodes fall through to a plain denied AccessAck.
    always_comb begin
        d_nxt        = '0;
        d_nxt.opcode = is_get ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
        d_nxt.size   = a_beat.size;
        d_nxt.denied = ~legal | (is_put & a_beat.corrupt);
        if (is_get) begin
            if (legal) d_nxt.data    = mem[word_idx];
            else       d_nxt.corrupt = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            d_vld_q <= 1'b0;
            d_q     <= '0;
            src_q   <= '0;
        end else if (a_fire) begin
            d_vld_q <= 1'b1;
            d_q     <= d_nxt;
            src_q   <= a_source;
        end else if (d_ready) begin
            d_vld_q <= 1'b0;
        end
    end

    assign d_valid   = d_vld_q;
    assign d_opcode  = d_q.opcode;
    assign d_param   = d_q.param;
    assign d_size    = d_q.size;
    assign d_source  = src_q;
    assign d_sink    = SINK_ID;
    assign d_denied  = d_q.denied;
    assign d_data    = d_q.data;
    assign d_corrupt = d_q.corrupt;

endmodule
